// File: rtl/sap_pkg.sv
// Shared types for the SAP register-file datapath.
//   alu_op_e      : 4-bit ALU operation code
//   flags_t       : packed z/n/c/v flag bundle
//   op_sets_flags : 1 when an op code updates the flags register
package sap_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        ALU_PASS = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_ADC  = 4'd6,
        ALU_SBC  = 4'd7,
        ALU_SHL  = 4'd8,
        ALU_SHR  = 4'd9,
        ALU_OUT  = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

    // PASS, OUT and unknown codes leave the flags untouched
    function automatic logic op_sets_flags(input logic [OP_W-1:0] op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
            ALU_ADC, ALU_SBC, ALU_SHL, ALU_SHR: op_sets_flags = 1'b1;
            default:                            op_sets_flags = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU for the SAP datapath.
//   a, b  : operands (N bits)      cin : carry/borrow in for ADC/SBC
//   op    : alu_op_e code          y   : result
//   z,n,c,v : flags derived from this operation
module datapath_alu
    import sap_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]    a,
    input  logic [N-1:0]    b,
    input  logic            cin,
    input  logic [OP_W-1:0] op,
    output logic [N-1:0]    y,
    output logic            z,
    output logic            n,
    output logic            c,
    output logic            v
);

    localparam int unsigned W = N + 1;

    logic [W-1:0] wide;
    logic         cin_eff;

    // Arithmetic in N+1 bits: bit N is carry for adds, borrow for subtracts
    always_comb begin
        wide    = '0;
        y       = a;
        c       = 1'b0;
        v       = 1'b0;
        cin_eff = ((op == ALU_ADC) || (op == ALU_SBC)) ? cin : 1'b0;
        case (op)
            ALU_ADD, ALU_ADC: begin
                wide = W'(a) + W'(b) + W'(cin_eff);
                y    = wide[N-1:0];
                c    = wide[N];
                v    = (a[N-1] == b[N-1]) && (y[N-1] != a[N-1]);
            end
            ALU_SUB, ALU_SBC: begin
                wide = W'(a) - W'(b) - W'(cin_eff);
                y    = wide[N-1:0];
                c    = wide[N];
                v    = (a[N-1] != b[N-1]) && (y[N-1] != a[N-1]);
            end
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SHL: begin
                y = {a[N-2:0], 1'b0};
                c = a[N-1];
            end
            ALU_SHR: begin
                y = {1'b0, a[N-1:1]};
                c = a[0];
            end
            default: y = a;
        endcase
        z = (y == '0);
        n = y[N-1];
    end

endmodule

// File: rtl/datapath_rf_pipe.sv
// SAP datapath: NREGS x N register file, valid/ready command port, one-stage
// execute register with write-back forwarding and a sticky flags register.
//   clk, reset_n                 : clock, async active-low reset
//   cmd_valid/cmd_ready          : command handshake
//   cmd_op/ra/rb/rd/imm/bus/we   : command fields; imm_data, bus_in operands
//   res_valid/res_ready/res_data : result handshake and registered result
//   out_reg                      : last result of an ALU_OUT command
//   z,n,c,v                      : flags as of the most recently accepted command
module datapath_rf_pipe
    import sap_pkg::*;
#(
    parameter  int unsigned N     = 8,
    parameter  int unsigned NREGS = 4,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [OP_W-1:0] cmd_op,
    input  logic [AW-1:0]   cmd_ra,
    input  logic [AW-1:0]   cmd_rb,
    input  logic [AW-1:0]   cmd_rd,
    input  logic            cmd_imm,
    input  logic            cmd_bus,
    input  logic            cmd_we,
    input  logic [N-1:0]    imm_data,
    input  logic [N-1:0]    bus_in,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [N-1:0]    res_data,
    output logic [N-1:0]    out_reg,
    output logic            z,
    output logic            n,
    output logic            c,
    output logic            v
);

    logic [N-1:0]  rf_q [NREGS];
    logic [N-1:0]  rf_d [NREGS];
    logic          ex_valid_q, ex_valid_d;
    logic [N-1:0]  ex_data_q,  ex_data_d;
    logic          ex_we_q,    ex_we_d;
    logic [AW-1:0] ex_rd_q,    ex_rd_d;
    logic          ex_out_q,   ex_out_d;
    flags_t        ex_flags_q, ex_flags_d;
    logic [N-1:0]  out_reg_q,  out_reg_d;

    logic          retire;
    logic          accept;
    logic [N-1:0]  opa;
    logic [N-1:0]  opb_reg;
    logic [N-1:0]  opb;
    logic [N-1:0]  alu_y;
    logic          alu_z, alu_n, alu_c, alu_v;
    flags_t        alu_flags;

    // Ready depends only on registered state and the consumer, never on cmd_valid
    assign cmd_ready = !ex_valid_q || res_ready;
    assign retire    = ex_valid_q && res_ready;
    assign accept    = cmd_valid && cmd_ready;

    // A retiring entry overrides the stale RF read of its destination
    always_comb begin
        opa     = rf_q[cmd_ra];
        opb_reg = rf_q[cmd_rb];
        if (retire && ex_we_q && (ex_rd_q == cmd_ra)) opa     = ex_data_q;
        if (retire && ex_we_q && (ex_rd_q == cmd_rb)) opb_reg = ex_data_q;
        opb = cmd_imm ? imm_data : opb_reg;
    end

    // ex_flags_q always holds the newest flag state, so carry needs no extra forward path
    datapath_alu #(.N(N)) u_alu (
        .a   (opa),
        .b   (opb),
        .cin (ex_flags_q.c),
        .op  (cmd_op),
        .y   (alu_y),
        .z   (alu_z),
        .n   (alu_n),
        .c   (alu_c),
        .v   (alu_v)
    );

    assign alu_flags = '{z: alu_z, n: alu_n, c: alu_c, v: alu_v};

    // Write-back on retire, capture of the new entry on accept
    always_comb begin
        rf_d       = rf_q;
        ex_valid_d = ex_valid_q;
        ex_data_d  = ex_data_q;
        ex_we_d    = ex_we_q;
        ex_rd_d    = ex_rd_q;
        ex_out_d   = ex_out_q;
        ex_flags_d = ex_flags_q;
        out_reg_d  = out_reg_q;
        if (retire) begin
            ex_valid_d = 1'b0;
            if (ex_we_q)  rf_d[ex_rd_q] = ex_data_q;
            if (ex_out_q) out_reg_d     = ex_data_q;
        end
        if (accept) begin
            ex_valid_d = 1'b1;
            ex_data_d  = cmd_bus ? bus_in : alu_y;
            ex_we_d    = cmd_we;
            ex_rd_d    = cmd_rd;
            ex_out_d   = (cmd_op == ALU_OUT);
            if (!cmd_bus && op_sets_flags(cmd_op)) ex_flags_d = alu_flags;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_q       <= '{default: '0};
            ex_valid_q <= 1'b0;
            ex_data_q  <= '0;
            ex_we_q    <= 1'b0;
            ex_rd_q    <= '0;
            ex_out_q   <= 1'b0;
            ex_flags_q <= '0;
            out_reg_q  <= '0;
        end else begin
            rf_q       <= rf_d;
            ex_valid_q <= ex_valid_d;
            ex_data_q  <= ex_data_d;
            ex_we_q    <= ex_we_d;
            ex_rd_q    <= ex_rd_d;
            ex_out_q   <= ex_out_d;
            ex_flags_q <= ex_flags_d;
            out_reg_q  <= out_reg_d;
        end
    end

    assign res_valid = ex_valid_q;
    assign res_data  = ex_data_q;
    assign out_reg   = out_reg_q;
    assign z         = ex_flags_q.z;
    assign n         = ex_flags_q.n;
    assign c         = ex_flags_q.c;
    assign v         = ex_flags_q.v;

endmodule

// File: tb/tb_datapath_rf_pipe.sv
// Scoreboard bench for datapath_rf_pipe: stimulus pushes reference-model
// results into a queue, a monitor pops and compares on every result handshake.
module tb_datapath_rf_pipe;

    localparam int NB   = 8;
    localparam int MASK = 255;

    typedef struct {
        int       data;
        bit [3:0] fl;     // {z,n,c,v}
        bit       is_out;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [1:0] cmd_ra, cmd_rb, cmd_rd;
    logic       cmd_imm, cmd_bus, cmd_we;
    logic [7:0] imm_data, bus_in;
    logic       res_valid, res_ready;
    logic [7:0] res_data, out_reg;
    logic       z, n, c, v;

    exp_t     exp_q[$];
    int       regs[4];
    bit [3:0] flags;
    int       mon_out;
    int       rdy_mode;   // 0: always ready, 1: random, 2: held low
    int       checks;
    int       errors;

    datapath_rf_pipe #(.N(NB), .NREGS(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
        .cmd_imm(cmd_imm), .cmd_bus(cmd_bus), .cmd_we(cmd_we),
        .imm_data(imm_data), .bus_in(bus_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .out_reg(out_reg), .z(z), .n(n), .c(c), .v(v)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic int sgn(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    // Reference ALU from the arithmetic definitions (signed range test for overflow)
    function automatic void ref_exec(input int op, input int a, input int b,
                                     input bit [3:0] fin, output int y, output bit [3:0] fout);
        int ci, s, sr;
        bit cf, vf;
        fout = fin;
        y    = a;
        ci   = 0;
        case (op)
            1, 6: begin
                if (op == 6) ci = int'(fin[1]);
                s  = a + b + ci;
                y  = s % 256;
                cf = (s > MASK);
                sr = sgn(a) + sgn(b) + ci;
                vf = (sr > 127) || (sr < -128);
                fout = {y == 0, y > 127, cf, vf};
            end
            2, 7: begin
                if (op == 7) ci = int'(fin[1]);
                s  = a - b - ci;
                y  = (s + 512) % 256;
                cf = (a < b + ci);
                sr = sgn(a) - sgn(b) - ci;
                vf = (sr > 127) || (sr < -128);
                fout = {y == 0, y > 127, cf, vf};
            end
            3, 4, 5: begin
                y = (op == 3) ? (a & b) : (op == 4) ? (a | b) : (a ^ b);
                fout = {y == 0, y > 127, 1'b0, 1'b0};
            end
            8: begin
                y = (a * 2) % 256;
                fout = {y == 0, y > 127, a > 127, 1'b0};
            end
            9: begin
                y = a / 2;
                fout = {y == 0, y > 127, (a % 2) == 1, 1'b0};
            end
            default: y = a;
        endcase
    endfunction

    // Drives one command from posedge+1; returns at posedge+1 after acceptance
    task automatic issue(input int op, input int ra, input int rb, input int rd,
                         input bit imm, input bit bus, input bit we,
                         input int immv, input int busv, output int waits);
        int a, b, y;
        bit [3:0] f;
        cmd_valid = 1'b1;
        cmd_op    = 4'(op);
        cmd_ra    = 2'(ra);
        cmd_rb    = 2'(rb);
        cmd_rd    = 2'(rd);
        cmd_imm   = imm;
        cmd_bus   = bus;
        cmd_we    = we;
        imm_data  = 8'(immv);
        bus_in    = 8'(busv);
        waits     = 0;
        @(negedge clk);
        while (!cmd_ready && waits < 64) begin
            waits++;
            @(posedge clk); #1;
            @(negedge clk);
        end
        if (!cmd_ready) begin
            chk("cmd_accept_timeout", int'(cmd_ready), 1);
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            return;
        end
        a = regs[ra];
        b = imm ? immv : regs[rb];
        if (bus) begin
            y = busv;
            f = flags;
        end else begin
            ref_exec(op, a, b, flags, y, f);
        end
        if (we) regs[rd] = y;
        flags = f;
        exp_q.push_back('{data: y, fl: f, is_out: (op == 10)});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        rdy_mode = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || res_valid) && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        chk("drain_pending", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    // Consumer-side ready generation
    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       res_ready = 1'b1;
                2:       res_ready = 1'b0;
                default: res_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pop and compare on every result handshake
    initial begin
        exp_t e;
        mon_out = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_q.delete();
                mon_out = 0;
            end else if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got 0x%0h with no pending command", res_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_data", int'(res_data), e.data);
                    chk("flags_znc_v", int'({z, n, c, v}), int'(e.fl));
                    chk("out_reg", int'(out_reg), mon_out);
                    if (e.is_out) mon_out = e.data;
                end
            end
        end
    end

    initial begin
        int w;
        checks = 0; errors = 0; rdy_mode = 0;
        flags = '0;
        foreach (regs[i]) regs[i] = 0;
        cmd_valid = 0; cmd_op = 0; cmd_ra = 0; cmd_rb = 0; cmd_rd = 0;
        cmd_imm = 0; cmd_bus = 0; cmd_we = 0; imm_data = 0; bus_in = 0;
        reset_n = 1'b0;
        #12;
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_flags", int'({z, n, c, v}), 0);
        chk("rst_out_reg", int'(out_reg), 0);
        #10 reset_n = 1'b1;
        @(posedge clk); #1;

        // Bus loads then ADD/SUB
        issue(0, 0, 0, 0, 0, 1, 1, 0, 8'h0A, w);
        issue(0, 0, 0, 1, 0, 1, 1, 0, 8'h05, w);
        issue(1, 0, 1, 2, 0, 0, 1, 0, 0, w);
        issue(2, 0, 1, 3, 0, 0, 1, 0, 0, w);

        // Carry chain: 0xFF + 1 then ADC picks up the pending carry
        issue(0, 0, 0, 0, 0, 1, 1, 0, 8'hFF, w);
        issue(1, 0, 0, 0, 1, 0, 1, 8'h01, 0, w);
        issue(6, 0, 0, 1, 1, 0, 1, 8'h00, 0, w);
        chk("adc_no_stall", w, 0);

        // Dependent back-to-back adds through the forwarding path
        issue(0, 0, 0, 0, 0, 1, 1, 0, 8'h10, w);
        issue(1, 0, 0, 1, 1, 0, 1, 8'h01, 0, w);
        issue(1, 1, 0, 2, 1, 0, 1, 8'h01, 0, w);
        chk("fwd_no_stall", w, 0);
        issue(0, 2, 0, 2, 0, 0, 0, 0, 0, w);

        // Signed overflow then OUT of r2
        issue(0, 0, 0, 0, 0, 1, 1, 0, 8'h7F, w);
        issue(1, 0, 0, 2, 1, 0, 1, 8'h01, 0, w);
        issue(10, 2, 0, 3, 0, 0, 0, 0, 0, w);
        drain();
        chk("out_reg_after_out", int'(out_reg), regs[2]);

        // Backpressure: entry held for 3 cycles, then one retire
        rdy_mode = 2;
        @(posedge clk); #1;
        issue(1, 0, 0, 3, 1, 0, 1, 8'h05, 0, w);
        repeat (3) begin
            @(negedge clk);
            chk("stall_cmd_ready", int'(cmd_ready), 0);
            chk("stall_res_valid", int'(res_valid), 1);
            chk("stall_res_data", int'(res_data), exp_q[0].data);
        end
        rdy_mode = 0;
        @(posedge clk); #1;
        issue(0, 3, 0, 3, 0, 0, 0, 0, 0, w);
        drain();

        // Randomised stream with random backpressure
        rdy_mode = 1;
        for (int k = 0; k < 300; k++) begin
            issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 1)) | ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), w);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        drain();
        chk("out_reg_random_end", int'(out_reg), mon_out);

        // Reset while a result is stalled
        rdy_mode = 2;
        @(posedge clk); #1;
        issue(1, 0, 0, 1, 1, 0, 1, 8'h33, 0, w);
        @(negedge clk);
        chk("pre_rst_res_valid", int'(res_valid), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_res_valid", int'(res_valid), 0);
        chk("mid_rst_flags", int'({z, n, c, v}), 0);
        chk("mid_rst_out_reg", int'(out_reg), 0);
        chk("mid_rst_res_data", int'(res_data), 0);
        foreach (regs[i]) regs[i] = 0;
        flags = '0;
        @(negedge clk);
        #3 reset_n = 1'b1;
        rdy_mode = 0;
        @(posedge clk); #1;
        for (int r = 0; r < 4; r++) issue(0, r, 0, r, 0, 0, 0, 0, 0, w);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
